v_issue_scoreboard: RTL and testbench

Hazard-tracking issue stage between the vector scheduler and the V_CU. It accepts decoded vector instructions over a valid/ready handshake and holds them in a one-entry output register. Each register has a pending-write counter; an instruction issues only when it reads no register with an outstanding write. Lane writeback reports clear the counters.

---
 rtl/v_issue_scoreboard.sv | 124 ++++++++++++
 tb/tb_v_issue_scoreboard.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/v_issue_scoreboard.sv
// Vector issue scoreboard: per-register pending-write counters gate issue of decoded
// instructions into a one-entry output register. Optional: V_SCB_WAW_STALL_EN serialises WAW.
module v_issue_scoreboard #(
    parameter int NUM_VREGS    = 32,
    parameter int CNT_W        = 3,
    parameter int MAX_INFLIGHT = 8
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        in_vld_i,
    output logic        in_rdy_o,
    input  logic [31:0] in_instr_i,
    input  logic        in_vs1_used_i,
    input  logic        in_vs2_used_i,
    input  logic        in_vd_rd_i,
    input  logic        in_vd_wr_i,
    output logic        out_vld_o,
    input  logic        out_rdy_i,
    output logic [31:0] out_instr_o,
    input  logic        wb_vld_i,
    input  logic [4:0]  wb_vd_i,
    input  logic        flush_i,
    output logic        stall_o,
    output logic [3:0]  inflight_o,
    output logic        err_o
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'((1 << CNT_W) - 1);
    localparam logic [3:0]       INF_MAX = 4'(MAX_INFLIGHT);

    logic [NUM_VREGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]  inflight_q, inflight_d;
    logic        err_q, err_d;
    logic        out_vld_q, out_vld_d;
    logic [31:0] out_instr_q, out_instr_d;
    logic        out_wr_q, out_wr_d;

    logic [4:0] in_vd, in_vs1, in_vs2, held_vd;
    logic       held_wr_vld, hazard, sat, waw, slot_free, accept, fire, inc_en, wb_ok;

    assign in_vd   = in_instr_i[11:7];
    assign in_vs1  = in_instr_i[19:15];
    assign in_vs2  = in_instr_i[24:20];
    assign held_vd = out_instr_q[11:7];

    // The held writer is not yet counted, so treat it as an extra pending write.
    assign held_wr_vld = out_vld_q && out_wr_q;

    always_comb begin
        hazard = 1'b0;
        if (in_vs1_used_i && (cnt_q[in_vs1] != '0 || (held_wr_vld && held_vd == in_vs1)))
            hazard = 1'b1;
        if (in_vs2_used_i && (cnt_q[in_vs2] != '0 || (held_wr_vld && held_vd == in_vs2)))
            hazard = 1'b1;
        if (in_vd_rd_i && (cnt_q[in_vd] != '0 || (held_wr_vld && held_vd == in_vd)))
            hazard = 1'b1;
    end

    // Saturation counts the held writer so neither a counter nor inflight can overflow.
    assign sat = in_vd_wr_i &&
                 ((cnt_q[in_vd] == CNT_MAX) ||
                  (held_wr_vld && held_vd == in_vd && cnt_q[in_vd] == CNT_MAX - 1'b1) ||
                  (inflight_q == INF_MAX) ||
                  (held_wr_vld && inflight_q == INF_MAX - 4'd1));

`ifdef V_SCB_WAW_STALL_EN
    assign waw = in_vd_wr_i && (cnt_q[in_vd] != '0 || (held_wr_vld && held_vd == in_vd));
`else
    assign waw = 1'b0;
`endif

    assign slot_free = !out_vld_q || out_rdy_i;
    assign in_rdy_o  = rstn && slot_free && !hazard && !sat && !waw && !flush_i;
    assign accept    = in_vld_i && in_rdy_o;
    assign fire      = out_vld_q && out_rdy_i;
    assign inc_en    = fire && out_wr_q;
    assign wb_ok     = wb_vld_i && (cnt_q[wb_vd_i] != '0);

    always_comb begin
        cnt_d      = cnt_q;
        inflight_d = inflight_q;
        err_d      = err_q;
        if (inc_en) cnt_d[held_vd] = cnt_d[held_vd] + 1'b1;
        if (wb_ok)  cnt_d[wb_vd_i] = cnt_d[wb_vd_i] - 1'b1;
        inflight_d = inflight_q + {3'b0, inc_en} - {3'b0, wb_ok};
        if (wb_vld_i && !wb_ok) err_d = 1'b1;
    end

    always_comb begin
        out_vld_d   = out_vld_q;
        out_instr_d = out_instr_q;
        out_wr_d    = out_wr_q;
        if (accept) begin
            out_vld_d   = 1'b1;
            out_instr_d = in_instr_i;
            out_wr_d    = in_vd_wr_i;
        end else if (fire || flush_i) begin
            out_vld_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q       <= '0;
            inflight_q  <= '0;
            err_q       <= 1'b0;
            out_vld_q   <= 1'b0;
            out_instr_q <= '0;
            out_wr_q    <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            inflight_q  <= inflight_d;
            err_q       <= err_d;
            out_vld_q   <= out_vld_d;
            out_instr_q <= out_instr_d;
            out_wr_q    <= out_wr_d;
        end
    end

    assign out_vld_o   = out_vld_q;
    assign out_instr_o = out_instr_q;
    assign inflight_o  = inflight_q;
    assign err_o       = err_q;
    assign stall_o     = in_vld_i && !in_rdy_o;
endmodule

// File: tb/tb_v_issue_scoreboard.sv
// Randomised bench for v_issue_scoreboard: an array-based register-pending model predicts
// handshakes; a separate monitor checks issued instruction words against a queue.
module tb_v_issue_scoreboard;
    logic        clk = 0, rstn = 0;
    logic        in_vld_i = 0, in_vs1_used_i = 0, in_vs2_used_i = 0, in_vd_rd_i = 0, in_vd_wr_i = 0;
    logic [31:0] in_instr_i = 0;
    logic        out_rdy_i = 0, wb_vld_i = 0, flush_i = 0;
    logic [4:0]  wb_vd_i = 0;
    logic        in_rdy_o, out_vld_o, stall_o, err_o;
    logic [31:0] out_instr_o;
    logic [3:0]  inflight_o;

    v_issue_scoreboard dut (
        .clk(clk), .rstn(rstn), .in_vld_i(in_vld_i), .in_rdy_o(in_rdy_o), .in_instr_i(in_instr_i),
        .in_vs1_used_i(in_vs1_used_i), .in_vs2_used_i(in_vs2_used_i), .in_vd_rd_i(in_vd_rd_i),
        .in_vd_wr_i(in_vd_wr_i), .out_vld_o(out_vld_o), .out_rdy_i(out_rdy_i),
        .out_instr_o(out_instr_o), .wb_vld_i(wb_vld_i), .wb_vd_i(wb_vd_i), .flush_i(flush_i),
        .stall_o(stall_o), .inflight_o(inflight_o), .err_o(err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0, n_fail = 0;
    // Reference state: outstanding writes per register, plus the held instruction.
    int cnt [32];
    int inflight;
    bit err_m, h_vld, h_wr;
    int h_vd;
    logic [31:0] exp_q [$];

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rstn && out_vld_o && out_rdy_i) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL issue: got %h expected nothing pending", out_instr_o);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                if (out_instr_o !== e) begin
                    n_fail++;
                    $display("FAIL issue: got %h expected %h", out_instr_o, e);
                end
            end
        end
    end

    function automatic logic [31:0] mk(input int vd, input int vs1, input int vs2);
        logic [4:0] d, a, b;
        d = 5'(vd); a = 5'(vs1); b = 5'(vs2);
        return {7'h01, b, a, 3'b000, d, 7'h57};
    endfunction

    // Writes still owed to register r, including the held-but-unissued writer.
    function automatic int pending(input int r);
        return cnt[r] + ((h_vld && h_wr && h_vd == r) ? 1 : 0);
    endfunction

    task automatic model_clear();
        foreach (cnt[i]) cnt[i] = 0;
        inflight = 0; err_m = 0; h_vld = 0; h_wr = 0; h_vd = 0;
        exp_q.delete();
    endtask

    task automatic do_reset();
        rstn = 0; in_vld_i = 1;
        @(negedge clk);
        check("rst_in_rdy", in_rdy_o, 0);
        check("rst_out_vld", out_vld_o, 0);
        check("rst_inflight", inflight_o, 0);
        check("rst_err", err_o, 0);
        model_clear();
        @(posedge clk); #1;
        rstn = 1; in_vld_i = 0;
    endtask

    task automatic step(input bit v, input logic [31:0] ins, input bit u1, input bit u2,
                        input bit ur, input bit uw, input bit ordy, input bit wbv,
                        input int wbd, input bit fl);
        int vd, vs1, vs2, total;
        bit hz, sat, exp_rdy, acc, fire;
        in_vld_i = v; in_instr_i = ins; in_vs1_used_i = u1; in_vs2_used_i = u2;
        in_vd_rd_i = ur; in_vd_wr_i = uw; out_rdy_i = ordy; wb_vld_i = wbv;
        wb_vd_i = 5'(wbd); flush_i = fl;
        @(negedge clk);
        vd = int'(ins[11:7]); vs1 = int'(ins[19:15]); vs2 = int'(ins[24:20]);
        hz = (u1 && pending(vs1) > 0) || (u2 && pending(vs2) > 0) || (ur && pending(vd) > 0);
        total = inflight + ((h_vld && h_wr) ? 1 : 0);
        sat = uw && (pending(vd) >= 7 || total >= 8);
        exp_rdy = !fl && (!h_vld || ordy) && !hz && !sat;
        acc = v && exp_rdy;
        check("in_rdy", in_rdy_o, exp_rdy);
        check("stall", stall_o, v && !exp_rdy);
        check("out_vld", out_vld_o, h_vld);
        check("inflight", inflight_o, inflight);
        check("err", err_o, err_m);
        // Advance the model across the coming edge.
        fire = h_vld && ordy;
        if (wbv) begin
            if (cnt[wbd] > 0) begin cnt[wbd]--; inflight--; end
            else err_m = 1;
        end
        if (fire && h_wr) begin cnt[h_vd]++; inflight++; end
        if (fl && h_vld && !ordy) void'(exp_q.pop_front());
        if (acc) begin
            h_vld = 1; h_wr = uw; h_vd = vd;
            exp_q.push_back(ins);
        end else if (fire || fl) h_vld = 0;
        @(posedge clk); #1;
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, 0, ordy, 0, 0, 0);
    endtask

    initial begin
        model_clear();
        in_vld_i = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset();

        // Single issue, then RAW on v3 resolved by writeback.
        step(1, 32'h022081D7, 1, 1, 0, 1, 1, 0, 0, 0);
        idle(1);
        for (int i = 0; i < 3; i++) step(1, 32'h02318257, 1, 1, 0, 1, 1, 0, 0, 0);
        step(1, 32'h02318257, 1, 1, 0, 1, 1, 1, 3, 0);
        step(1, 32'h02318257, 1, 1, 0, 1, 1, 0, 0, 0);
        idle(1); idle(1);

        // Inflight limit with independent writers v1..v9.
        do_reset();
        for (int i = 1; i <= 9; i++) step(1, mk(i, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(1, mk(9, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0);

        // Same-cycle increment and writeback on v5.
        do_reset();
        step(1, mk(5, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0);
        step(1, mk(5, 0, 0), 0, 0, 0, 1, 1, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 5, 0);
        idle(1); idle(1);

        // Flush without handshake, then writeback to an idle register.
        step(1, mk(10, 0, 0), 0, 0, 0, 1, 0, 0, 0, 0);
        step(1, mk(11, 0, 0), 0, 0, 0, 1, 0, 0, 0, 1);
        idle(0);
        step(0, 0, 0, 0, 0, 0, 1, 1, 7, 0);
        for (int i = 0; i < 3; i++) idle(1);

        // Randomised traffic over a small register window to provoke hazards.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            int q_nz [$];
            bit wbv;
            int wbd;
            if ($urandom_range(0, 499) == 0) begin do_reset(); continue; end
            foreach (cnt[i]) if (cnt[i] > 0) q_nz.push_back(i);
            wbv = 0; wbd = 0;
            if (q_nz.size() > 0 && $urandom_range(0, 99) < 35) begin
                wbv = 1; wbd = q_nz[$urandom_range(0, q_nz.size() - 1)];
            end else if ($urandom_range(0, 199) == 0) begin
                wbv = 1; wbd = $urandom_range(0, 31);
            end
            step($urandom_range(0, 99) < 70,
                 mk($urandom_range(0, 7), $urandom_range(0, 7), $urandom_range(0, 7)),
                 1'($urandom), 1'($urandom), $urandom_range(0, 99) < 20,
                 $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 70,
                 wbv, wbd, $urandom_range(0, 99) < 4);
        end
        for (int i = 0; i < 4; i++) idle(1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
